// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide/modulo unit.
package muldiv_pkg;

    // Operation select as presented on the mode port.
    typedef enum logic [1:0] {
        MD_DIV  = 2'd0,
        MD_MOD  = 2'd1,
        MD_MUL  = 2'd2,
        MD_RSVD = 2'd3
    } mode_e;

    // Control states of the unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Quotient returned on divide-by-zero: all ones, sliced to the operand width.
    // Supports WIDTH up to DBZ_MAX_W.
    localparam int unsigned          DBZ_MAX_W = 64;
    localparam logic [DBZ_MAX_W-1:0] DBZ_QUOT  = '1;

endpackage

// File: rtl/muldiv_pow2_detect.sv
// Combinational classifier for operand B: zero, exact power of two, and the
// bit position of the single set bit (shift amount for the fast path).
module muldiv_pow2_detect
    import muldiv_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SH_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] b,
    output logic             is_zero,
    output logic             is_pow2,
    output logic [SH_W-1:0]  shamt
);

    logic [WIDTH-1:0] w_bm1;

    assign w_bm1   = b - WIDTH'(1);
    assign is_zero = (b == '0);
    assign is_pow2 = !is_zero && ((b & w_bm1) == '0);

    // Position of the highest set bit; equals k when b == 2^k.
    always_comb begin
        shamt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (b[i]) shamt = SH_W'(i);
        end
    end

endmodule

// File: rtl/seq_muldivmod.sv
// Multi-cycle unsigned divide / modulo / multiply with valid/ready handshakes.
// Zero, power-of-two B and the reserved mode complete in one cycle; all other
// operations iterate one bit per cycle for WIDTH cycles.
module seq_muldivmod
    import muldiv_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             dbz
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    state_e           r_state, w_state_nxt;
    mode_e            r_mode;
    logic [WIDTH-1:0] r_a;      // dividend shifting out / quotient shifting in; multiplicand for mul
    logic [WIDTH-1:0] r_b;      // divisor (constant) or multiplier (shifting right)
    logic [WIDTH-1:0] r_rem;    // partial remainder
    logic [WIDTH-1:0] r_acc;    // partial product
    logic [WIDTH-1:0] r_y;
    logic             r_dbz;
    logic [CNT_W-1:0] r_cnt;

    mode_e            w_mode_in;
    logic             w_is_zero, w_is_pow2;
    logic [SH_W-1:0]  w_shamt;
    logic             w_fast, w_accept, w_last;
    logic [WIDTH-1:0] w_mask, w_fast_y;
    logic             w_fast_dbz;
    logic [WIDTH:0]   w_trial, w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_rem_nxt, w_acc_nxt, w_res;

    muldiv_pow2_detect #(.WIDTH(WIDTH)) u_pow2 (
        .b       (b),
        .is_zero (w_is_zero),
        .is_pow2 (w_is_pow2),
        .shamt   (w_shamt)
    );

    assign w_mode_in = mode_e'(mode);
    assign w_fast    = w_is_zero || w_is_pow2 || (w_mode_in == MD_RSVD);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign y         = r_y;
    assign dbz       = r_dbz;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = w_fast ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Single-cycle result for B == 0, B == 2^k and the reserved mode.
    always_comb begin
        w_fast_y   = '0;
        w_fast_dbz = 1'b0;
        w_mask     = (WIDTH'(1) << w_shamt) - WIDTH'(1);
        if (w_mode_in != MD_RSVD) begin
            if (w_is_zero) begin
                unique case (w_mode_in)
                    MD_DIV: begin w_fast_y = DBZ_QUOT[WIDTH-1:0]; w_fast_dbz = 1'b1; end
                    MD_MOD: begin w_fast_y = a;                   w_fast_dbz = 1'b1; end
                    default: w_fast_y = '0;
                endcase
            end else begin
                unique case (w_mode_in)
                    MD_DIV:  w_fast_y = a >> w_shamt;
                    MD_MOD:  w_fast_y = a & w_mask;
                    default: w_fast_y = a << w_shamt;
                endcase
            end
        end
    end

    // One iteration step: restoring divide (MSB first) or shift-add multiply.
    always_comb begin
        w_trial   = {r_rem, r_a[WIDTH-1]};
        w_diff    = w_trial - {1'b0, r_b};
        w_ge      = !w_diff[WIDTH];
        w_a_nxt   = r_a;
        w_b_nxt   = r_b;
        w_rem_nxt = r_rem;
        w_acc_nxt = r_acc;
        if (r_mode == MD_MUL) begin
            if (r_b[0]) w_acc_nxt = r_acc + r_a;
            w_a_nxt = r_a << 1;
            w_b_nxt = r_b >> 1;
        end else begin
            w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
            // quotient bits enter at the LSB as dividend bits leave the MSB
            w_a_nxt   = {r_a[WIDTH-2:0], w_ge};
        end
        w_res = w_acc_nxt;
        if (r_mode == MD_DIV)      w_res = w_a_nxt;
        else if (r_mode == MD_MOD) w_res = w_rem_nxt;
    end

    // Operand capture, iteration registers and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MD_DIV;
            r_a    <= '0;
            r_b    <= '0;
            r_rem  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_y    <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_mode <= w_mode_in;
            r_a    <= a;
            r_b    <= b;
            r_rem  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            if (w_fast) begin
                r_y   <= w_fast_y;
                r_dbz <= w_fast_dbz;
            end
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_rem <= w_rem_nxt;
            r_acc <= w_acc_nxt;
            if (w_last) begin
                r_y   <= w_res;
                r_dbz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_muldivmod.sv
// Directed bench for seq_muldivmod (WIDTH=8). A reference model derived from
// plain arithmetic checks every cycle; directed vectors pin literal values.
module tb_seq_muldivmod;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] y;
    logic         dbz;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] y;
        logic         dbz;
        int           lat;
        int           acc;
    } exp_t;

    exp_t cur;
    bit   busy = 1'b0;
    bit   seen = 1'b0;
    bit   late = 1'b0;

    seq_muldivmod #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: result from plain arithmetic, latency from the operand class.
    function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t        e;
        int unsigned ai, bi, prod;
        bit          fast;
        ai    = av;
        bi    = bv;
        e.y   = '0;
        e.dbz = 1'b0;
        e.acc = 0;
        fast  = (bi == 0) || (m == 2'd3);
        for (int k = 0; k < W; k++) if (bi == (32'd1 << k)) fast = 1'b1;
        case (m)
            2'd0: if (bi == 0) begin e.y = 8'hFF; e.dbz = 1'b1; end else e.y = W'(ai / bi);
            2'd1: if (bi == 0) begin e.y = av;    e.dbz = 1'b1; end else e.y = W'(ai % bi);
            2'd2: begin prod = ai * bi; e.y = W'(prod % 256); end
            default: e.y = '0;
        endcase
        e.lat = fast ? 1 : W + 1;
        return e;
    endfunction

    // Compare process: inputs change just after posedge, so negedge values
    // are the ones seen by the next active edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            busy = 1'b0;
            seen = 1'b0;
            late = 1'b0;
        end else begin
            chk("in_ready", in_ready, !busy);
            if (busy) begin
                if (out_valid) begin
                    if (!seen) chk("latency", cyc - cur.acc, cur.lat);
                    seen = 1'b1;
                    chk("model_y", y, cur.y);
                    chk("model_dbz", dbz, cur.dbz);
                    if (out_ready) begin
                        busy = 1'b0;
                        seen = 1'b0;
                        late = 1'b0;
                    end
                end else if (!late && (cyc - cur.acc >= cur.lat)) begin
                    late = 1'b1;
                    chk("out_valid_late", 0, 1);
                end
            end else begin
                chk("spurious_out_valid", out_valid, 0);
            end
            if (in_valid && in_ready) begin
                cur     = model(mode, a, b);
                cur.acc = cyc;
                busy    = 1'b1;
                seen    = 1'b0;
                late    = 1'b0;
            end
        end
    end

    task automatic issue(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(posedge clk); #1;
        in_valid = 1'b1; mode = m; a = av; b = bv;
        @(posedge clk); #1;
        // operands change after acceptance; the unit must not notice
        in_valid = 1'b0; mode = 2'($urandom_range(0, 3)); a = W'($urandom); b = W'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack();
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic [1:0] m, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input int ey, input int ed, input int el);
        int lat;
        issue(m, av, bv);
        wait_result(lat);
        chk({name, "_lat"}, lat, el);
        chk({name, "_y"}, y, ey);
        chk({name, "_dbz"}, dbz, ed);
        ack();
    endtask

    initial begin
        int lat;
        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_y", y, 0);
        chk("reset_dbz", dbz, 0);
        @(posedge clk); #3; rst_n = 1'b1;

        run("div0", 2'd0, 8'd200, 8'd0, 255, 1, 1);
        run("mod0", 2'd1, 8'd200, 8'd0, 200, 1, 1);
        run("mul0", 2'd2, 8'd200, 8'd0, 0, 0, 1);
        run("div8", 2'd0, 8'd200, 8'd8, 25, 0, 1);
        run("mod8", 2'd1, 8'd200, 8'd8, 0, 0, 1);
        run("mul8", 2'd2, 8'd200, 8'd8, 64, 0, 1);
        run("div1", 2'd0, 8'd200, 8'd1, 200, 0, 1);
        run("mod1", 2'd1, 8'd200, 8'd1, 0, 0, 1);
        run("mul1", 2'd2, 8'd200, 8'd1, 200, 0, 1);
        run("rsvd", 2'd3, 8'd200, 8'd7, 0, 0, 1);
        run("div7", 2'd0, 8'd200, 8'd7, 28, 0, 9);
        run("mod7", 2'd1, 8'd200, 8'd7, 4, 0, 9);
        run("mul7", 2'd2, 8'd200, 8'd7, 120, 0, 9);
        run("div3", 2'd0, 8'd255, 8'd3, 85, 0, 9);
        run("mulff", 2'd2, 8'd255, 8'd255, 1, 0, 9);
        run("div_small", 2'd0, 8'd5, 8'd200, 0, 0, 9);
        run("mod_small", 2'd1, 8'd5, 8'd200, 5, 0, 9);
        run("mod128", 2'd1, 8'd255, 8'd128, 127, 0, 1);

        // Backpressure: result held, new requests ignored while busy.
        issue(2'd0, 8'd200, 8'd7);
        wait_result(lat);
        chk("bp_lat", lat, 9);
        repeat (5) begin
            @(posedge clk); #1;
            in_valid = 1'b1; mode = 2'd0; a = 8'd100; b = 8'd3;
            @(negedge clk);
            chk("bp_y", y, 28);
            chk("bp_dbz", dbz, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_in_ready", in_ready, 1);
        @(posedge clk); #1; in_valid = 1'b0;
        wait_result(lat);
        chk("bp_next_lat", lat, 9);
        chk("bp_next_y", y, 33);
        ack();

        // Reset during the fourth CALC cycle.
        issue(2'd0, 8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        run("post_rst_mul", 2'd2, 8'd13, 8'd11, 143, 0, 9);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
